ps2_host_tx: RTL

PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It is the opposite direction of the existing PS/2 scancode receiver and shares the same open-drain clock/data lines. It runs on the system clock, oversamples the keyboard clock, and drives the lines low through output-enables only; the pad logic ties each line to 0 when its oe=1.

---
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Purpose : byte-request handshake between a command source and the PS/2 host transmitter.
// Latency : n/a (signal bundle only).
// Backpressure: tx_ready is high only while the transmitter is idle; tx_valid is ignored otherwise.
//   tx_data  [7:0] command byte to send
//   tx_valid       request; the byte is taken when tx_valid && tx_ready
//   tx_ready       transmitter idle and able to accept a byte
//   busy           transmitter in any state other than idle
//   tx_done        one-cycle pulse: byte sent and device acknowledged
//   tx_err         one-cycle pulse: missing ack or watchdog timeout
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, tx_done, tx_err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, tx_done, tx_err
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Purpose : PS/2 host-to-device transmitter; sends one command byte over open-drain clk/data lines.
// Latency : INHIBIT_CYCLES of clock inhibit, then 11 device clocks plus ack; done/err 1 cycle after ack.
// Backpressure: one byte in flight; tx_ready drops on acceptance and returns the cycle after done/err.
//   clk, rst_n              system clock, asynchronous active-low reset
//   tx (ps2_host_tx_if)     byte request handshake and status pulses
//   ps2_clk_i, ps2_data_i   raw asynchronous PS/2 line levels
//   ps2_clk_oe, ps2_data_oe 1 = pull the line low (lines are never driven high)
// Optional macro PS2_TX_TIMEOUT_EN: adds a watchdog that aborts with tx_err after
// TIMEOUT_CYCLES from request-to-send; without it the FSM waits for the device indefinitely.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic          clk,
   input  logic          rst_n,
   ps2_host_tx_if.slave  tx,
   input  logic          ps2_clk_i,
   input  logic          ps2_data_i,
   output logic          ps2_clk_oe,
   output logic          ps2_data_oe
);

   localparam int IW = $clog2(INHIBIT_CYCLES);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

   // Both counters need at least one bit of width.
   if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_WAIT_IDLE, S_DONE, S_ERR
   } state_t;

   state_t          state, state_n;
   logic            clk_meta, clk_s, clk_s_d;
   logic            data_meta, data_s;
   logic            fe;
   logic [8:0]      shift_q, shift_n;       // {parity, data}, shifted out LSB first
   logic [3:0]      edge_cnt, edge_cnt_n;   // device falling edges seen so far
   logic            data_drv, data_drv_n;   // 1 = hold data low during DATA
   logic [IW-1:0]   inh_cnt, inh_cnt_n;
   logic            to_hit;

   // Line synchronisers; idle lines float high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta  <= 1'b1;
         clk_s     <= 1'b1;
         clk_s_d   <= 1'b1;
         data_meta <= 1'b1;
         data_s    <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk_i;
         clk_s     <= clk_meta;
         clk_s_d   <= clk_s;
         data_meta <= ps2_data_i;
         data_s    <= data_meta;
      end
   end

   assign fe = clk_s_d & ~clk_s;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;
   logic          to_active;

   // Watchdog covers request-to-send through the end of the ack.
   assign to_active = (state == S_REQ) || (state == S_DATA) || (state == S_WAIT_IDLE);
   assign to_hit    = to_active && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         to_cnt <= '0;
      else if (to_active) to_cnt <= to_cnt + TW'(1);
      else                to_cnt <= '0;
   end
`else
   // No watchdog: only rst_n recovers a hung or absent device.
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         shift_q  <= '0;
         edge_cnt <= '0;
         data_drv <= 1'b0;
         inh_cnt  <= '0;
      end else begin
         state    <= state_n;
         shift_q  <= shift_n;
         edge_cnt <= edge_cnt_n;
         data_drv <= data_drv_n;
         inh_cnt  <= inh_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      shift_n    = shift_q;
      edge_cnt_n = edge_cnt;
      data_drv_n = data_drv;
      inh_cnt_n  = inh_cnt;
      case (state)
         S_IDLE: begin
            if (tx.tx_valid) begin
               shift_n    = {~^tx.tx_data, tx.tx_data};
               edge_cnt_n = '0;
               inh_cnt_n  = '0;
               data_drv_n = 1'b0;
               state_n    = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt == INH_LAST) state_n = S_REQ;
            else                     inh_cnt_n = inh_cnt + IW'(1);
         end
         S_REQ, S_DATA: begin
            if (fe) begin
               edge_cnt_n = edge_cnt + 4'd1;
               state_n    = S_DATA;
               if (edge_cnt <= 4'd8) begin
                  // Edges 1..9: eight data bits then parity.
                  data_drv_n = ~shift_q[0];
                  shift_n    = {1'b0, shift_q[8:1]};
               end else if (edge_cnt == 4'd9) begin
                  // Edge 10: release data for the stop bit.
                  data_drv_n = 1'b0;
               end else begin
                  // Edge 11: device must be holding data low as its ack.
                  data_drv_n = 1'b0;
                  state_n    = data_s ? S_ERR : S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (clk_s && data_s) state_n = S_DONE;
         end
         S_DONE, S_ERR: state_n = S_IDLE;
         default:       state_n = S_IDLE;
      endcase
      if (to_hit) begin
         state_n    = S_ERR;
         data_drv_n = 1'b0;
      end
   end

   // All outputs decode the state register, so async reset releases the lines at once.
   assign tx.tx_ready = (state == S_IDLE);
   assign tx.busy     = (state != S_IDLE);
   assign tx.tx_done  = (state == S_DONE);
   assign tx.tx_err   = (state == S_ERR);
   assign ps2_clk_oe  = (state == S_INHIBIT);
   // Start bit is put on the line in the last inhibit cycle so it is valid when clk is released.
   assign ps2_data_oe = ((state == S_INHIBIT) && (inh_cnt == INH_LAST))
                        || (state == S_REQ)
                        || ((state == S_DATA) && data_drv);

endmodule
